// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and sign helper for the EX-stage ALU/MDU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    // Widest value the sign helper handles: a 2*WIDTH product, so WIDTH <= 64.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    // Two's-complement negate when neg is set; gives magnitude of a signed value.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Shared shift-add multiply / restoring divide datapath, one bit per step.
// Latency: WIDTH steps after load; last is high during the final step.
// Backpressure: none; steps whenever step is asserted by the controlling FSM.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] rdiff;
    logic             ge;

    // Multiply: acc_lo holds the remaining multiplier bits and collects product low bits.
    assign msum  = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & m};
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign rsh   = {acc_hi, acc_lo[WIDTH-1]};
    assign ge    = rsh >= {1'b0, m};
    assign rdiff = WIDTH'(rsh - {1'b0, m});
    assign last  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            m      <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= op_a;
            m      <= op_b;
            cnt    <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
            if (is_div) begin
                acc_hi <= ge ? rdiff : rsh[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ge};
            end else begin
                acc_hi <= msum[WIDTH:1];
                acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide and architectural HI/LO.
// Latency: 1 cycle for logic/arith/MFHI/MFLO, WIDTH+1 cycles for MULT*/DIV*.
// Backpressure: busy stalls the pipeline; start is ignored while busy.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zout,
    output logic             sout,
    output logic             vout,
    output logic             divz
);
    import alu_pkg::*;

    state_t           state;
    logic             sa, sb, bz, is_div_q;
    logic [WIDTH-1:0] a_q;
    logic             signed_op, is_multi, launch;
    logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo;
    logic             last;
    logic [WIDTH-1:0] sum, diff, sc_res;
    logic             sc_v, sc_known;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic             fix_divz;

    assign signed_op = ~alu_control[0];
    assign is_multi  = (alu_control[3:2] == 2'b10);
    assign launch    = (state == IDLE) && start && is_multi;
    assign mag_a     = WIDTH'(cond_neg(MAX_W'(a), signed_op && a[WIDTH-1]));
    assign mag_b     = WIDTH'(cond_neg(MAX_W'(b), signed_op && b[WIDTH-1]));

    mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .step   ((state == MUL) || (state == DIV)),
        .is_div (state == DIV),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .last   (last)
    );

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        sc_res   = '0;
        sc_v     = 1'b0;
        sc_known = 1'b1;
        case (alu_control)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_ADD: begin
                sc_res = sum;
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            default: sc_known = 1'b0;
        endcase
    end

    // Sign fix-up of the magnitude result; MIN / -1 wraps back to MIN with a zero remainder.
    assign prod = (2*WIDTH)'(cond_neg(MAX_W'({acc_hi, acc_lo}), sa ^ sb));

    always_comb begin
        fix_hi   = prod[2*WIDTH-1:WIDTH];
        fix_lo   = prod[WIDTH-1:0];
        fix_divz = 1'b0;
        if (is_div_q) begin
            if (bz) begin
                fix_hi   = a_q;
                fix_lo   = '1;
                fix_divz = 1'b1;
            end else begin
                fix_hi = WIDTH'(cond_neg(MAX_W'(acc_hi), sa));
                fix_lo = WIDTH'(cond_neg(MAX_W'(acc_lo), sa ^ sb));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            alu_out  <= '0;
            hi       <= '0;
            lo       <= '0;
            zout     <= 1'b0;
            sout     <= 1'b0;
            vout     <= 1'b0;
            divz     <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            bz       <= 1'b0;
            is_div_q <= 1'b0;
            a_q      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_multi) begin
                        state    <= alu_control[1] ? DIV : MUL;
                        busy     <= 1'b1;
                        sa       <= signed_op && a[WIDTH-1];
                        sb       <= signed_op && b[WIDTH-1];
                        bz       <= (b == '0);
                        is_div_q <= alu_control[1];
                        a_q      <= a;
                    end else if (start) begin
                        done    <= 1'b1;
                        alu_out <= sc_res;
                        zout    <= sc_known && (sc_res == '0);
                        sout    <= sc_res[WIDTH-1];
                        vout    <= sc_v;
                        divz    <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (last)
                        state <= FIX;
                end
                FIX: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    hi      <= fix_hi;
                    lo      <= fix_lo;
                    alu_out <= fix_lo;
                    zout    <= (fix_lo == '0);
                    sout    <= fix_lo[WIDTH-1];
                    vout    <= 1'b0;
                    divz    <= fix_divz;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32 and WIDTH=16 with hand-computed expectations.
module tb_alu_mdu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [3:0]  ctrl;
    logic [31:0] a, b, alu_out, hi, lo;
    logic        busy, done, zout, sout, vout, divz;

    logic        start16;
    logic [3:0]  ctrl16;
    logic [15:0] a16, b16, out16, hi16, lo16;
    logic        busy16, done16, z16, s16, v16, d16;

    int checks = 0;
    int errors = 0;
    int cyc, bcyc, dn;

    alu_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start), .alu_control(ctrl), .a(a), .b(b),
        .busy(busy), .done(done), .alu_out(alu_out), .hi(hi), .lo(lo),
        .zout(zout), .sout(sout), .vout(vout), .divz(divz)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .alu_control(ctrl16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .alu_out(out16), .hi(hi16), .lo(lo16),
        .zout(z16), .sout(s16), .vout(v16), .divz(d16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Drive start for one edge from the current negedge; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        ctrl  = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c, output int bc);
        c  = 0;
        bc = 0;
        while (!done && c < 100) begin
            if (busy) bc++;
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
        start16 = 1'b0; ctrl16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_out", alu_out, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_ctl", {busy, done, zout, sout, vout, divz}, 0);
        chk("rst16", {busy16, done16, out16, hi16, lo16}, 0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
        chk("add_done", done, 1);
        chk("add_out", alu_out, 32'h8000_0000);
        chk("add_flags", {busy, zout, sout, vout, divz}, 5'b00110);
        @(negedge clk);
        chk("done_pulse", done, 0);

        issue(4'b0110, 32'h8000_0000, 32'h1);
        chk("sub_ovf_out", alu_out, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", {zout, sout, vout, divz}, 4'b0010);
        issue(4'b0110, 32'd5, 32'd5);
        chk("sub_zero", {alu_out, zout, sout, vout}, {32'h0, 3'b100});
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("and", alu_out, 32'hF000_F000);
        issue(4'b0100, 32'h0, 32'h0);
        chk("nor", {alu_out, zout, sout}, {32'hFFFF_FFFF, 2'b01});
        issue(4'b0011, 32'h1234_5678, 32'hFFFF_0000);
        chk("xor", alu_out, 32'hEDCB_5678);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
        chk("slt", {alu_out, zout}, {32'h1, 1'b0});
        issue(4'b0101, 32'hFFFF_FFFF, 32'h1);
        chk("sltu", {alu_out, zout}, {32'h0, 1'b1});
        issue(4'b1110, 32'h5, 32'h5);
        chk("undef", {done, alu_out, zout, sout, vout, divz}, {1'b1, 32'h0, 4'b0000});

        // MULT with a start attempt mid-flight that must be ignored.
        issue(4'b1000, 32'hFFFF_FFFE, 32'h3);
        chk("mult_busy", {busy, done}, 2'b10);
        cyc = 0; bcyc = 0;
        while (!done && cyc < 100) begin
            if (busy) bcyc++;
            if (cyc == 5) begin
                ctrl = 4'b0010; a = 32'h1; b = 32'h1; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("mult_lat", cyc, 33);
        chk("mult_busy_cyc", bcyc, 33);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("mult_out", {busy, alu_out, zout, sout, vout, divz}, {1'b0, 32'hFFFF_FFFA, 4'b0100});

        issue(4'b1100, 32'h0, 32'h0);
        chk("mfhi", {done, alu_out, sout}, {1'b1, 32'hFFFF_FFFF, 1'b1});
        issue(4'b1101, 32'h0, 32'h0);
        chk("mflo", alu_out, 32'hFFFF_FFFA);

        issue(4'b1010, 32'hFFFF_FFF9, 32'h2);
        wait_done(cyc, bcyc);
        chk("div_lat", cyc, 33);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_flags", {alu_out, zout, sout, vout, divz}, {32'hFFFF_FFFD, 4'b0100});

        issue(4'b1011, 32'd100, 32'd7);
        wait_done(cyc, bcyc);
        chk("divu", {hi, lo}, {32'd2, 32'd14});

        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bcyc);
        chk("div_minneg", {hi, lo, vout, divz}, {32'h0, 32'h8000_0000, 2'b00});

        issue(4'b1011, 32'd7, 32'd0);
        wait_done(cyc, bcyc);
        chk("divz_lat", cyc, 33);
        chk("divz_hilo", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
        chk("divz_flags", {alu_out, zout, sout, vout, divz}, {32'hFFFF_FFFF, 4'b0101});

        issue(4'b0001, 32'h0000_00F0, 32'h0000_000F);
        chk("or_keeps_hilo", {alu_out, hi, lo, divz}, {32'hFF, 32'd7, 32'hFFFF_FFFF, 1'b0});

        // Abort a DIV with reset sampled at start+10.
        issue(4'b1010, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {busy, done, alu_out, hi, lo}, 0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abort_quiet", dn, 0);

        ctrl16 = 4'b1001; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("w16_lat", cyc, 17);
        chk("w16_hilo", {hi16, lo16}, 32'hFFFE_0001);
        chk("w16_out", {out16, z16, s16, v16, d16}, {16'h0001, 4'b0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, registered successor of the single-cycle MIPS-lite ALU. It keeps the ALU operation codes and adds an iterative multiply/divide unit with architectural HI/LO registers, MFHI/MFLO, SLTU, a correct signed-subtract overflow rule and a start/done handshake. It sits in the EX stage. The pipeline stalls on `busy` while a multi-cycle operation runs.

## Interface
Parameters:
- `WIDTH`, 32: operand, result and HI/LO width. Must be an even number, at least 8.
- `CNT_W`, $clog2(WIDTH)+1: width of the iteration counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch the operation on `a`, `b`, `alu_control`. Ignored while `busy`=1.
- `alu_control` in 4: operation code (see Operation).
- `a`, `b` in WIDTH: operands, sampled only in the `start` cycle.
- `busy` out 1: a multi-cycle operation is in flight.
- `done` out 1: one-cycle pulse when the result is valid.
- `alu_out` out WIDTH: result. Holds its value until the next `done`.
- `hi`, `lo` out WIDTH: architectural HI/LO registers.
- `zout` out 1: zero flag.
- `sout` out 1: sign flag.
- `vout` out 1: overflow flag.
- `divz` out 1: divide-by-zero flag.

## Operation
- `alu_control` codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR
  - 0110 SUB, 0111 SLT (signed), 0101 SLTU
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU
  - 1100 MFHI, 1101 MFLO
  - Any other code: `alu_out`=0, all flags 0, `done` still pulses.
- Single-cycle ops (every code below 1000, plus 1100 and 1101): result and flags are registered at the `start` edge. SLT and SLTU return 1 or 0, zero-extended.
- Overflow, set only by ADD and SUB:
  - ADD: `vout` = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - SUB: `vout` = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]).
  - All other ops: `vout`=0.
- `zout` = (`alu_out`==0). `sout` = `alu_out`[W-1]. Both are updated with every `done`.
- MULT/MULTU: shift-add, one bit per cycle. Signed operands are handled by magnitude plus sign fix-up. {hi,lo} receives the full 2W product; `alu_out` = lo.
- DIV/DIVU: restoring division, one bit per cycle. lo = quotient, hi = remainder, `alu_out` = lo.
  - Signed division truncates toward zero; the remainder takes the sign of `a`.
  - Signed most-negative / -1: lo = most-negative, hi = 0, `vout`=0.
  - `b`==0: lo = all-ones, hi = `a`, `divz`=1 with `done`. Same latency as a normal divide.
- `divz` = 0 on every `done` that is not a divide-by-zero.
- HI/LO change only at MULT*/DIV* completion.
- FSM states:
  - IDLE → MUL or DIV on `start` with a multi-cycle code.
  - MUL/DIV → FIX when the counter reaches WIDTH.
  - FIX → IDLE: sign correction, `done` pulse.

## Timing
- Reset values: `alu_out`, `hi`, `lo` = 0; `busy`, `done`, all flags = 0; state = IDLE; counter = 0.
- Single-cycle latency: `start` at edge N → `done`=1 after edge N. `busy` stays 0.
- Multi-cycle latency: `start` at edge N → `busy`=1 after edge N → `done`=1 after edge N+WIDTH+1. `busy` falls in the same cycle that `done` rises.
- `start` is accepted again in the cycle `done` is high. Back-to-back operations are allowed.
- MFHI/MFLO issued the cycle after a MULT/DIV `done` return the new HI/LO values.
- `start` while `busy`: no effect on operands, state or outputs.
- `reset` mid-operation aborts it. Outputs go to reset values on the next edge, with no `done` pulse.
- `reset` and `start` in the same cycle: `reset` wins.

## Structure
- Package `alu_pkg` holds:
  - the `alu_control` opcode localparams;
  - the FSM state enum (IDLE, MUL, DIV, FIX);
  - a helper function for signed magnitude/negate.
- Sub-module `mdu_iter`: the shared shift-add / restoring-divide datapath and its counter, controlled by the top-level FSM. Single-cycle ops stay in `alu_mdu`.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 1 → `alu_out` 0x80000000, `vout`=1, `sout`=1, `done` one cycle after `start`.
- SUB 0x80000000 - 1 → 0x7FFFFFFF, `vout`=1. SUB 5 - 5 → 0, `zout`=1, `vout`=0.
- MULT 0xFFFFFFFE × 3 → hi 0xFFFFFFFF, lo 0xFFFFFFFA, `done` at start+33, `busy` high for 33 cycles. Then MFHI → 0xFFFFFFFF.
- DIV -7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIVU 7 / 0 → lo 0xFFFFFFFF, hi 7, `divz`=1.
- SLT -1 vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. A `start` issued while `busy` leaves the in-flight MULT result unchanged.
- `reset` at start+10 of a DIV → no `done`, hi/lo = 0, `busy`=0. Then WIDTH=16 regression: MULTU 0xFFFF × 0xFFFF → hi 0xFFFE, lo 0x0001, `done` at start+17.
